// File: rtl/arb_pkg.sv
// Shared definitions for the two-master video RAM bus arbiter: state encoding,
// bus widths and the fill value returned on an aborted (timed-out) read.
package arb_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  localparam logic [DATA_W-1:0] TIMEOUT_FILL = 8'hFF;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/bus_arbiter2.sv
// Two-master / one-slave bus arbiter with anti-starvation for master 1.
// Optional ack watchdog enabled by defining ARB_TIMEOUT_EN.
module bus_arbiter2
  import arb_pkg::*;
#(
  parameter int M0_BURST_MAX = 8,
  parameter int TIMEOUT      = 255
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_m0_cs,
  input  logic              i_m0_we,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_dat,
  output logic [DATA_W-1:0] o_m0_dat,
  output logic              o_m0_ack,
  input  logic              i_m1_cs,
  input  logic              i_m1_we,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_dat,
  output logic [DATA_W-1:0] o_m1_dat,
  output logic              o_m1_ack,
  output logic              o_s_cs,
  output logic              o_s_we,
  output logic [ADDR_W-1:0] o_s_addr,
  output logic [DATA_W-1:0] o_s_dat,
  input  logic [DATA_W-1:0] i_s_dat,
  input  logic              i_s_ack,
  output logic              o_timeout
);

  localparam int BURST_W = $clog2(M0_BURST_MAX + 1);

  arb_state_t         state;
  logic [BURST_W-1:0] burst_cnt;
  logic               gnt0;
  logic               gnt1;
  logic               gnt_cs;
  logic               to_hit;
  logic               burst_full;

  assign gnt0       = (state == ARB_GNT0);
  assign gnt1       = (state == ARB_GNT1);
  assign gnt_cs     = (gnt0 && i_m0_cs) || (gnt1 && i_m1_cs);
  assign burst_full = (burst_cnt == BURST_W'(M0_BURST_MAX));

`ifdef ARB_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       timeout_q;

  // Fires in the TIMEOUT-th grant cycle without ack; abort by cs drop wins.
  assign to_hit    = gnt_cs && !i_s_ack && (wait_cnt == 8'(TIMEOUT - 1));
  assign o_timeout = timeout_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == ARB_IDLE) begin
        wait_cnt <= '0;
      end else if (!i_s_ack) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (to_hit) begin
        timeout_q <= 1'b1;
      end
    end
  end
`else
  logic [31:0] unused_timeout;

  assign unused_timeout = 32'(TIMEOUT);
  assign to_hit         = 1'b0;
  assign o_timeout      = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= ARB_IDLE;
      burst_cnt <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (i_m1_cs && (!i_m0_cs || burst_full)) begin
            state     <= ARB_GNT1;
            burst_cnt <= '0;
          end else if (i_m0_cs) begin
            state <= ARB_GNT0;
            // m1 high here implies the counter is below the limit
            if (i_m1_cs) begin
              burst_cnt <= burst_cnt + 1'b1;
            end else begin
              burst_cnt <= '0;
            end
          end else begin
            burst_cnt <= '0;
          end
        end
        default: begin
          if (i_s_ack || !gnt_cs || to_hit) begin
            state <= ARB_IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    o_s_cs   = 1'b0;
    o_s_we   = 1'b0;
    o_s_addr = '0;
    o_s_dat  = '0;
    o_m0_dat = '0;
    o_m1_dat = '0;
    case (state)
      ARB_GNT0: begin
        o_s_cs   = i_m0_cs;
        o_s_we   = i_m0_we;
        o_s_addr = i_m0_addr;
        o_s_dat  = i_m0_dat;
        o_m0_dat = to_hit ? TIMEOUT_FILL : i_s_dat;
      end
      ARB_GNT1: begin
        o_s_cs   = i_m1_cs;
        o_s_we   = i_m1_we;
        o_s_addr = i_m1_addr;
        o_s_dat  = i_m1_dat;
        o_m1_dat = to_hit ? TIMEOUT_FILL : i_s_dat;
      end
      default: ;
    endcase
  end

  // A reset arriving mid-grant must not let a late slave ack through.
  assign o_m0_ack = gnt0 && !i_reset && (i_s_ack || to_hit);
  assign o_m1_ack = gnt1 && !i_reset && (i_s_ack || to_hit);

endmodule

// File: tb/tb_bus_arbiter2.sv
// Directed plus randomized bench for bus_arbiter2 against a behavioural model
// of grant ownership, m0 streak length and the optional ARB_TIMEOUT_EN watchdog.
module tb_bus_arbiter2;

  localparam int BURST = 8;
  localparam int TMO   = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cs, m0_we, m1_cs, m1_we;
  logic [15:0] m0_addr, m1_addr;
  logic [7:0]  m0_wdat, m1_wdat;
  logic [7:0]  m0_rdat, m1_rdat;
  logic        m0_ack, m1_ack;
  logic        s_cs, s_we, s_ack;
  logic [15:0] s_addr;
  logic [7:0]  s_wdat, s_rdat;
  logic        tmo_flag;

  int checks = 0;
  int errors = 0;

  // Behavioural model: who owns the bus (-1 nobody), m0 grants in a row while
  // m1 waited, sticky timeout, and grant cycles already spent without ack.
  int owner  = -1;
  int streak = 0;
  bit tflag  = 1'b0;
  int waited = 0;

  always #5 clk = ~clk;

  bus_arbiter2 #(.M0_BURST_MAX(BURST), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_m0_cs(m0_cs), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_dat(m0_wdat),
    .o_m0_dat(m0_rdat), .o_m0_ack(m0_ack),
    .i_m1_cs(m1_cs), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_dat(m1_wdat),
    .o_m1_dat(m1_rdat), .o_m1_ack(m1_ack),
    .o_s_cs(s_cs), .o_s_we(s_we), .o_s_addr(s_addr), .o_s_dat(s_wdat),
    .i_s_dat(s_rdat), .i_s_ack(s_ack), .o_timeout(tmo_flag)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic owner_cs();
    if (owner == 0) return m0_cs;
    if (owner == 1) return m1_cs;
    return 1'b0;
  endfunction

  function automatic logic timeout_now();
    return TO_EN && (owner >= 0) && owner_cs() && !s_ack && (waited + 1 == TMO);
  endfunction

  task automatic model_check();
    logic [25:0] exp_s;
    logic [8:0]  exp_m0, exp_m1;
    logic [7:0]  rd;
    logic        ak;
    exp_s  = '0;
    exp_m0 = '0;
    exp_m1 = '0;
    rd = timeout_now() ? 8'hFF : s_rdat;
    ak = !rst && (s_ack || timeout_now());
    if (owner == 0) begin
      exp_s  = {m0_cs, m0_we, m0_addr, m0_wdat};
      exp_m0 = {ak, rd};
    end else if (owner == 1) begin
      exp_s  = {m1_cs, m1_we, m1_addr, m1_wdat};
      exp_m1 = {ak, rd};
    end
    check("slave_bus", 32'({s_cs, s_we, s_addr, s_wdat}), 32'(exp_s));
    check("m0_resp", 32'({m0_ack, m0_rdat}), 32'(exp_m0));
    check("m1_resp", 32'({m1_ack, m1_rdat}), 32'(exp_m1));
    check("timeout_flag", 32'(tmo_flag), 32'(tflag));
  endtask

  task automatic model_edge();
    bit tnow;
    tnow = timeout_now();
    if (rst) begin
      owner = -1; streak = 0; tflag = 1'b0; waited = 0;
    end else if (owner < 0) begin
      waited = 0;
      if (m1_cs && (!m0_cs || streak == BURST)) begin
        owner = 1; streak = 0;
      end else if (m0_cs) begin
        owner = 0;
        streak = m1_cs ? ((streak < BURST) ? streak + 1 : BURST) : 0;
      end else begin
        streak = 0;
      end
    end else begin
      if (tnow) tflag = 1'b1;
      if (s_ack || !owner_cs() || tnow) owner = -1;
      else waited++;
    end
  endtask

  // Inputs are driven at posedge+2; outputs compared at +3, model advanced before the edge.
  task automatic tick();
    #1;
    model_check();
    model_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    m0_cs = 0; m0_we = 0; m0_addr = '0; m0_wdat = '0;
    m1_cs = 0; m1_we = 0; m1_addr = '0; m1_wdat = '0;
    s_ack = 0; s_rdat = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); #2;
    tick();
    tick();
    #1;
    check("rst_s_cs", 32'(s_cs), 32'd0);
    check("rst_acks", 32'({m0_ack, m1_ack}), 32'd0);
    check("rst_timeout", 32'(tmo_flag), 32'd0);
    rst = 1'b0;
    tick();

    // m0 read of 0x1234, slave answers A5 two cycles into the grant
    m0_cs = 1; m0_addr = 16'h1234;
    tick();
    #1;
    check("m0rd_addr", 32'(s_addr), 32'h1234);
    check("m0rd_cs", 32'(s_cs), 32'd1);
    tick();
    tick();
    s_ack = 1; s_rdat = 8'hA5;
    #1;
    check("m0rd_ack", 32'({m0_ack, m0_rdat}), 32'h1A5);
    check("m0rd_m1_quiet", 32'({m1_ack, m1_rdat}), 32'd0);
    tick();
    m0_cs = 0; s_ack = 0; s_rdat = 8'h00;
    #1;
    check("m0rd_done", 32'({m0_ack, s_cs}), 32'd0);
    tick();

    // simultaneous requests with immediate acks: m0 first, m1 write after the gap
    m0_cs = 1; m0_addr = 16'h0100;
    m1_cs = 1; m1_we = 1; m1_addr = 16'h0040; m1_wdat = 8'h3C;
    s_ack = 1; s_rdat = 8'h11;
    tick();
    #1;
    check("both_m0_first", 32'({m0_ack, m1_ack}), 32'h2);
    check("both_m0_addr", 32'(s_addr), 32'h0100);
    tick();
    m0_cs = 0;
    #1;
    check("both_gap", 32'(s_cs), 32'd0);
    tick();
    #1;
    check("both_m1_bus", 32'({s_cs, s_we, s_addr, s_wdat}), 32'({1'b1, 1'b1, 16'h0040, 8'h3C}));
    check("both_m1_ack", 32'({m0_ack, m1_ack}), 32'h1);
    tick();
    m1_cs = 0; m1_we = 0; s_ack = 0;
    tick();

    // both masters requesting continuously: 8 m0 transfers, then one m1
    m0_cs = 1; m1_cs = 1; s_ack = 1;
    for (int k = 0; k < 27; k++) begin
      tick();
      #1;
      check($sformatf("fair_xfer%0d", k), 32'({m1_ack, m0_ack}),
            (k % (BURST + 1) == BURST) ? 32'h2 : 32'h1);
      tick();
    end
    idle_inputs();
    tick();

    // m1 abandons its grant; a later slave ack reaches nobody
    m1_cs = 1; m1_addr = 16'h0BAD;
    tick();
    #1;
    check("abort_granted", 32'(s_cs), 32'd1);
    m1_cs = 0;
    #1;
    check("abort_no_ack", 32'(m1_ack), 32'd0);
    tick();
    s_ack = 1;
    #1;
    check("abort_late_ack", 32'({m0_ack, m1_ack}), 32'd0);
    tick();
    s_ack = 0;
    tick();

    // reset in the middle of an m0 grant with the ack still outstanding
    m0_cs = 1; m0_addr = 16'h2222;
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0; s_ack = 1; s_rdat = 8'h5A;
    #1;
    check("rstmid_cs", 32'(s_cs), 32'd0);
    check("rstmid_acks", 32'({m0_ack, m1_ack}), 32'd0);
    tick();
    #1;
    check("rstmid_regrant", 32'({s_cs, m0_ack, m0_rdat}), 32'h35A);
    tick();
    idle_inputs();
    tick();

    // m1 read that the slave never answers
    m1_cs = 1; m1_addr = 16'h0777;
    tick();
`ifdef ARB_TIMEOUT_EN
    for (int w = 1; w < TMO; w++) begin
      #1;
      check($sformatf("tmo_wait%0d", w), 32'({s_cs, m1_ack}), 32'h2);
      tick();
    end
    #1;
    check("tmo_pulse", 32'({m1_ack, m1_rdat}), 32'h1FF);
    tick();
    #1;
    check("tmo_released", 32'(s_cs), 32'd0);
    check("tmo_sticky", 32'(tmo_flag), 32'd1);
    m1_cs = 0;
    tick();
    m0_cs = 1; s_ack = 1; s_rdat = 8'h42;
    tick();
    #1;
    check("tmo_next_ok", 32'({m0_ack, m0_rdat, tmo_flag}), 32'h285);
    tick();
`else
    for (int w = 0; w < 12; w++) begin
      #1;
      check($sformatf("hold_cycle%0d", w), 32'({s_cs, m1_ack, tmo_flag}), 32'h4);
      tick();
    end
`endif
    idle_inputs();
    tick();

    // randomized traffic against the model
    for (int r = 0; r < 600; r++) begin
      rst     = ($urandom_range(0, 79) == 0);
      m0_cs   = ($urandom_range(0, 9) < 6);
      m1_cs   = ($urandom_range(0, 9) < 5);
      m0_we   = 1'($urandom);
      m1_we   = 1'($urandom);
      m0_addr = 16'($urandom);
      m1_addr = 16'($urandom);
      m0_wdat = 8'($urandom);
      m1_wdat = 8'($urandom);
      s_ack   = ($urandom_range(0, 3) == 0);
      s_rdat  = 8'($urandom);
      tick();
    end
    rst = 0;
    idle_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
